// File: rtl/cam_stream_capture_if.sv
//==============================================================================
// cam_stream_capture_if : DVP camera input and tagged camera->PSRAM FIFO port
// Rev 1.0
//==============================================================================
`default_nettype none

interface cam_stream_capture_if #(
   parameter int DATA_W          = 8,
   parameter int BYTES_PER_PIXEL = 2
);
   localparam int PIX_W = DATA_W * BYTES_PER_PIXEL;

   logic              cam_vsync;
   logic              cam_href;
   logic [DATA_W-1:0] cam_data;
   logic              fifo_full;
   logic [PIX_W:0]    fifo_data;
   logic              fifo_wr_en;

   modport master (
      input  cam_vsync, cam_href, cam_data, fifo_full,
      output fifo_data, fifo_wr_en
   );

   modport slave (
      output cam_vsync, cam_href, cam_data, fifo_full,
      input  fifo_data, fifo_wr_en
   );
endinterface

`default_nettype wire

// File: rtl/cam_stream_capture.sv
//==============================================================================
// cam_stream_capture : DVP capture, pixel packing and tagged FIFO writes with
// drop/line telemetry. Optional crop window enabled by define CAM_CROP_EN.
// Rev 1.0
//==============================================================================
`default_nettype none

module cam_stream_capture #(
   parameter int DATA_W          = 8,
   parameter int BYTES_PER_PIXEL = 2,
   parameter bit MSB_FIRST       = 1'b1,
   parameter int MAX_LINE        = 1024,
   parameter bit EMIT_EOL        = 1'b0,
   parameter int CROP_X0         = 0,
   parameter int CROP_Y0         = 0,
   parameter int CROP_W          = 480,
   parameter int CROP_H          = 272,
   localparam int PIX_W          = DATA_W * BYTES_PER_PIXEL,
   localparam int LINE_W         = $clog2(MAX_LINE + 1)
) (
   input  wire logic               PixelClk,
   input  wire logic               nRST,
   input  wire logic               mem_ready_i,
   cam_stream_capture_if.master    bus,
   output logic                    frame_active_o,
   output logic [15:0]             frame_count_o,
   output logic [LINE_W-1:0]       last_line_len_o,
   output logic [15:0]             drop_count_o,
   output logic                    overflow_o
);

   localparam int                BI_W      = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
   localparam logic [BI_W-1:0]   LAST_BYTE = BI_W'(BYTES_PER_PIXEL - 1);
   localparam logic [LINE_W-1:0] MAX_COL   = LINE_W'(MAX_LINE);

   if (BYTES_PER_PIXEL < 1 || BYTES_PER_PIXEL > 4 || CROP_X0 < 0 || CROP_Y0 < 0 ||
       CROP_W < 0 || CROP_H < 0) begin : g_param_check
      $error("cam_stream_capture: parameter out of range");
   end

   typedef enum logic [1:0] {
      S_WAIT_READY = 2'd0,
      S_WAIT_VSYNC = 2'd1,
      S_WAIT_FRAME = 2'd2,
      S_CAPTURE    = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [BI_W-1:0]   byte_idx_q, byte_idx_d;
   logic [PIX_W-1:0]  pix_q, pix_d;
   logic [LINE_W-1:0] col_q, col_d;
   logic [15:0]       row_q, row_d;
   logic              href_q, href_d;
   logic [PIX_W:0]    wdata_q, wdata_d;
   logic              wr_q, wr_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;
   logic [LINE_W-1:0] len_q, len_d;
   logic [15:0]       drop_q, drop_d;
   logic              ovf_q, ovf_d;

   logic [PIX_W-1:0]  w_pix;
   logic              w_emit;
   logic [PIX_W:0]    w_word;

`ifdef CAM_CROP_EN
   logic [LINE_W-1:0] lwr_q, lwr_d;
   logic              w_col_in, w_row_in;

   assign w_col_in = (int'(col_q) >= CROP_X0) && (int'(col_q) < CROP_X0 + CROP_W);
   assign w_row_in = (int'(row_q) >= CROP_Y0) && (int'(row_q) < CROP_Y0 + CROP_H);
`endif

   always_comb begin
      state_d     = state_q;
      byte_idx_d  = byte_idx_q;
      pix_d       = pix_q;
      col_d       = col_q;
      row_d       = row_q;
      href_d      = bus.cam_href;
      wdata_d     = wdata_q;
      wr_d        = 1'b0;
      frame_cnt_d = frame_cnt_q;
      len_d       = len_q;
      drop_d      = drop_q;
      ovf_d       = ovf_q;
`ifdef CAM_CROP_EN
      lwr_d       = lwr_q;
`endif
      w_emit      = 1'b0;
      w_word      = '0;

      // Current byte merged into its slot; completes the pixel on the last byte.
      w_pix = pix_q;
      for (int s = 0; s < BYTES_PER_PIXEL; s++) begin
         if (int'(byte_idx_q) == s) begin
            if (MSB_FIRST) w_pix[(BYTES_PER_PIXEL-1-s)*DATA_W +: DATA_W] = bus.cam_data;
            else           w_pix[s*DATA_W +: DATA_W]                     = bus.cam_data;
         end
      end

      if (!mem_ready_i) begin
         state_d    = S_WAIT_READY;
         byte_idx_d = '0;
      end else begin
         case (state_q)
            S_WAIT_READY: state_d = S_WAIT_VSYNC;
            S_WAIT_VSYNC: if (bus.cam_vsync) state_d = S_WAIT_FRAME;
            S_WAIT_FRAME: begin
               if (!bus.cam_vsync) begin
                  state_d    = S_CAPTURE;
                  byte_idx_d = '0;
                  col_d      = '0;
                  row_d      = '0;
`ifdef CAM_CROP_EN
                  lwr_d      = '0;
`endif
                  w_emit     = 1'b1;
                  w_word     = {1'b1, PIX_W'(frame_cnt_q)};
               end
            end
            S_CAPTURE: begin
               if (bus.cam_vsync) begin
                  state_d     = S_WAIT_FRAME;
                  frame_cnt_d = frame_cnt_q + 16'd1;
                  byte_idx_d  = '0;
               end else if (href_q && !bus.cam_href) begin
                  byte_idx_d = '0;
                  if (col_q != '0) begin
                     row_d = row_q + 16'd1;
                     col_d = '0;
`ifdef CAM_CROP_EN
                     lwr_d = '0;
                     if (w_row_in) begin
                        len_d = lwr_q;
                        if (EMIT_EOL) begin
                           w_emit = 1'b1;
                           w_word = '1;
                        end
                     end
`else
                     len_d = col_q;
                     if (EMIT_EOL) begin
                        w_emit = 1'b1;
                        w_word = '1;
                     end
`endif
                  end
               end else if (bus.cam_href) begin
                  pix_d = w_pix;
                  if (byte_idx_q == LAST_BYTE) begin
                     byte_idx_d = '0;
                     if (col_q < MAX_COL) begin
                        col_d = col_q + LINE_W'(1);
`ifdef CAM_CROP_EN
                        if (w_col_in && w_row_in) begin
                           lwr_d  = lwr_q + LINE_W'(1);
                           w_emit = 1'b1;
                           w_word = {1'b0, w_pix};
                        end
`else
                        w_emit = 1'b1;
                        w_word = {1'b0, w_pix};
`endif
                     end
                  end else begin
                     byte_idx_d = byte_idx_q + BI_W'(1);
                  end
               end
            end
            default: state_d = S_WAIT_READY;
         endcase
      end

      if (w_emit) begin
         if (bus.fifo_full) begin
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
            ovf_d = 1'b1;
         end else begin
            wr_d    = 1'b1;
            wdata_d = w_word;
         end
      end
   end

   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST) begin
         state_q     <= S_WAIT_READY;
         byte_idx_q  <= '0;
         pix_q       <= '0;
         col_q       <= '0;
         row_q       <= '0;
         href_q      <= 1'b0;
         wdata_q     <= '0;
         wr_q        <= 1'b0;
         frame_cnt_q <= '0;
         len_q       <= '0;
         drop_q      <= '0;
         ovf_q       <= 1'b0;
`ifdef CAM_CROP_EN
         lwr_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         byte_idx_q  <= byte_idx_d;
         pix_q       <= pix_d;
         col_q       <= col_d;
         row_q       <= row_d;
         href_q      <= href_d;
         wdata_q     <= wdata_d;
         wr_q        <= wr_d;
         frame_cnt_q <= frame_cnt_d;
         len_q       <= len_d;
         drop_q      <= drop_d;
         ovf_q       <= ovf_d;
`ifdef CAM_CROP_EN
         lwr_q       <= lwr_d;
`endif
      end
   end

   assign bus.fifo_data   = wdata_q;
   assign bus.fifo_wr_en  = wr_q;
   assign frame_active_o  = (state_q == S_CAPTURE);
   assign frame_count_o   = frame_cnt_q;
   assign last_line_len_o = len_q;
   assign drop_count_o    = drop_q;
   assign overflow_o      = ovf_q;

endmodule

`default_nettype wire
